// File: rtl/multiplier_arbiter_pkg.sv
// Shared helpers for the multiplier arbiter slice.
//   calc_lat : multiplier latency from its extra-register count
//   id_width : requester id width (at least 1 bit)
package multiplier_pkg;

  function automatic int calc_lat(input int nb_extra_reg);
    return nb_extra_reg + 1;
  endfunction

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multiplier_arbiter_if.sv
// Requester-side bundle of the multiplier arbiter.
//   req_* : per-requester operand channel (valid/ready), flattened operands
//   rsp_* : per-requester result channel; data and id are shared
// master = requester side, slave = arbiter side.
interface multiplier_arbiter_if
  import multiplier_pkg::*;
#(
  parameter int NB_REQ  = 4,
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 32
);
  localparam int ID_W = id_width(NB_REQ);

  logic [NB_REQ-1:0]           req_valid;
  logic [NB_REQ-1:0]           req_ready;
  logic [NB_REQ-1:0]           req_signed;
  logic [NB_REQ*WIDTH_A-1:0]   req_a;
  logic [NB_REQ*WIDTH_B-1:0]   req_b;
  logic [NB_REQ-1:0]           rsp_valid;
  logic [NB_REQ-1:0]           rsp_ready;
  logic [WIDTH_A+WIDTH_B-1:0]  rsp_data;
  logic [ID_W-1:0]             rsp_id;

  modport master (
    output req_valid, req_signed, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_signed, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/multiplier_arbiter_rr_arbiter.sv
// Round-robin arbiter.
//   req      : request vector
//   advance  : grant may be taken this cycle (pointer moves only then)
//   grant_oh : one-hot grant (0 when no request)
//   grant_id : granted id; falls back to the last granted id when idle
//   gvld     : any request pending
// Search starts one past the last granted id and wraps.
module rr_arbiter
  import multiplier_pkg::*;
#(
  parameter  int NB_REQ = 4,
  localparam int ID_W   = id_width(NB_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NB_REQ-1:0] req,
  input  logic              advance,
  output logic [NB_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]   grant_id,
  output logic              gvld
);

  logic [ID_W-1:0] last;
  logic            found;
  int              idx;

  always_comb begin
    grant_oh = '0;
    grant_id = last;
    gvld     = |req;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NB_REQ; off++) begin
      idx = (int'(last) + off) % NB_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
    if (gvld) grant_oh[grant_id] = 1'b1;
  end

  // Reset to the top id so requester 0 wins the first search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              last <= ID_W'(NB_REQ - 1);
    else if (gvld && advance) last <= grant_id;
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Shares one external pipelined multiplier between NB_REQ requesters.
//   clk, rst_n     : clock, async active-low reset
//   bus (slave)    : requester operand/result channels
//   mult_enable    : multiplier clock enable (low while the head is stalled)
//   mult_is_signed, mult_a, mult_b : operands to the multiplier
//   mult_out       : multiplier product
// A {vld,id} tag travels alongside the multiplier so the product at its
// output can be routed back to whoever issued it.
module multiplier_arbiter
  import multiplier_pkg::*;
#(
  parameter  int NB_REQ       = 4,
  parameter  int WIDTH_A      = 32,
  parameter  int WIDTH_B      = 32,
  parameter  int NB_EXTRA_REG = 4,
  localparam int ID_W         = id_width(NB_REQ),
  localparam int LAT          = calc_lat(NB_EXTRA_REG)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multiplier_arbiter_if.slave        bus,
  output logic                       mult_enable,
  output logic                       mult_is_signed,
  output logic [WIDTH_A-1:0]         mult_a,
  output logic [WIDTH_B-1:0]         mult_b,
  input  logic [WIDTH_A+WIDTH_B-1:0] mult_out
);

  localparam int STAGES = LAT - 1;

  logic [NB_REQ-1:0]            grant_oh;
  logic [ID_W-1:0]              grant_id;
  logic                         gvld;
  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][ID_W-1:0]    id_pipe;
  logic                         head_vld;
  logic [ID_W-1:0]              head_id;
  logic                         stall;

  rr_arbiter #(.NB_REQ(NB_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.req_valid),
    .advance  (mult_enable),
    .grant_oh (grant_oh),
    .grant_id (grant_id),
    .gvld     (gvld)
  );

  assign head_vld    = vld_pipe[STAGES];
  assign head_id     = id_pipe[STAGES];
  // An empty head never stalls, so bubbles drain even with no rsp_ready.
  assign stall       = head_vld & ~bus.rsp_ready[head_id];
  assign mult_enable = ~stall;

  // When idle the arbiter reports the last id, so the mux holds a
  // previous requester's operands; the tag vld of 0 masks them.
  assign mult_a         = bus.req_a[grant_id*WIDTH_A +: WIDTH_A];
  assign mult_b         = bus.req_b[grant_id*WIDTH_B +: WIDTH_B];
  assign mult_is_signed = bus.req_signed[grant_id];

  assign bus.req_ready = (gvld && mult_enable) ? grant_oh : '0;
  assign bus.rsp_data  = mult_out;
  assign bus.rsp_id    = head_id;

  always_comb begin
    bus.rsp_valid = '0;
    if (head_vld) bus.rsp_valid[head_id] = 1'b1;
  end

  // Tag pipeline advances in lockstep with the multiplier enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else if (mult_enable) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], gvld};
      id_pipe  <= {id_pipe[STAGES-1:0], grant_id};
    end
  end

endmodule

// File: tb/tb_multiplier_arbiter.sv
module tb_multiplier_arbiter;
  import multiplier_pkg::*;

  localparam int NB_REQ       = 4;
  localparam int WIDTH_A      = 8;
  localparam int WIDTH_B      = 8;
  localparam int NB_EXTRA_REG = 2;
  localparam int LAT          = calc_lat(NB_EXTRA_REG);

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        mult_enable, mult_is_signed;
  logic [7:0]  mult_a, mult_b;
  logic [15:0] mult_out;

  int n_tot = 0;
  int n_bad = 0;

  multiplier_arbiter_if #(.NB_REQ(NB_REQ), .WIDTH_A(WIDTH_A), .WIDTH_B(WIDTH_B)) bus ();

  multiplier_arbiter #(
    .NB_REQ(NB_REQ), .WIDTH_A(WIDTH_A), .WIDTH_B(WIDTH_B), .NB_EXTRA_REG(NB_EXTRA_REG)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .mult_enable    (mult_enable),
    .mult_is_signed (mult_is_signed),
    .mult_a         (mult_a),
    .mult_b         (mult_b),
    .mult_out       (mult_out)
  );

  always #5 clk = ~clk;

  // Reference multiplier: LAT register stages, enable, no reset.
  logic [15:0] ea, eb;
  logic [15:0] mpipe [LAT];
  always_comb begin
    ea = mult_is_signed ? {{8{mult_a[7]}}, mult_a} : {8'h00, mult_a};
    eb = mult_is_signed ? {{8{mult_b[7]}}, mult_b} : {8'h00, mult_b};
  end
  always_ff @(posedge clk) begin
    if (mult_enable) begin
      mpipe[0] <= ea * eb;
      for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
  end
  assign mult_out = mpipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
    bus.req_signed[i]   = s;
  endtask

  task automatic do_reset();
    nxt();
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
  endtask

  // Single requester 0, result expected exactly LAT cycles after accept.
  task automatic single(input logic s, input logic [15:0] exp, input string tag);
    set_op(0, 8'hFF, 8'h02, s);
    bus.rsp_ready = '1;
    bus.req_valid = 4'b0001;
    #1 chk({tag, "_rdy"}, 32'(bus.req_ready), 32'h1);
    nxt(); bus.req_valid = '0;
    #1 chk({tag, "_c1"}, 32'(bus.rsp_valid), 32'h0);
    nxt();
    #1 chk({tag, "_c2"}, 32'(bus.rsp_valid), 32'h0);
    nxt();
    #1 chk({tag, "_vld"}, 32'(bus.rsp_valid), 32'h1);
    chk({tag, "_data"}, 32'(bus.rsp_data), 32'(exp));
    nxt();
  endtask

  initial begin
    bus.req_valid = '0; bus.req_signed = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_enable",    32'(mult_enable),   32'h1);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
    nxt(); rst_n = 1'b1;

    // 1: signed and unsigned 0xFF * 0x02
    single(1'b1, 16'hFFFE, "t1s");
    single(1'b0, 16'h01FE, "t1u");

    // 2: all four continuously, round-robin 0..3
    do_reset();
    for (int i = 0; i < NB_REQ; i++) set_op(i, 8'(i + 1), 8'd3, 1'b0);
    bus.rsp_ready = '1;
    bus.req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1 chk("t2_rdy", 32'(bus.req_ready), 32'(1 << (c % 4)));
      if (c >= 3) begin
        chk("t2_vld",  32'(bus.rsp_valid), 32'(1 << ((c - 3) % 4)));
        chk("t2_id",   32'(bus.rsp_id),    32'((c - 3) % 4));
        chk("t2_data", 32'(bus.rsp_data),  32'((((c - 3) % 4) + 1) * 3));
      end else begin
        chk("t2_vld0", 32'(bus.rsp_valid), 32'h0);
      end
      nxt();
    end
    bus.req_valid = '0;
    repeat (4) nxt();

    // 3: requester 1 backpressures its result for 5 cycles
    do_reset();
    bus.rsp_ready = 4'b1101;
    bus.req_valid = '1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("t3_rdy", 32'(bus.req_ready), 32'(1 << c));
      nxt();
    end
    for (int c = 4; c < 9; c++) begin
      #1;
      chk("t3_en",    32'(mult_enable),   32'h0);
      chk("t3_rdy0",  32'(bus.req_ready), 32'h0);
      chk("t3_vld",   32'(bus.rsp_valid), 32'h2);
      chk("t3_hold",  32'(bus.rsp_data),  32'd6);
      nxt();
    end
    bus.rsp_ready = '1;
    for (int c = 9; c < 14; c++) begin
      #1;
      chk("t3_id",   32'(bus.rsp_id),    32'((c - 8) % 4));
      chk("t3_data", 32'(bus.rsp_data),  32'((((c - 8) % 4) + 1) * 3));
      chk("t3_gnt",  32'(bus.req_ready), 32'(1 << ((c - 9) % 4)));
      nxt();
    end
    bus.req_valid = '0;
    repeat (4) nxt();

    // 4: no rsp_ready, requester 2 back-to-back: 3 accepts then stall
    do_reset();
    set_op(2, 8'd5, 8'd7, 1'b0);
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1 chk("t4_acc", 32'(bus.req_ready), 32'h4);
      nxt();
    end
    for (int c = 3; c < 5; c++) begin
      #1;
      chk("t4_en",   32'(mult_enable),   32'h0);
      chk("t4_rdy",  32'(bus.req_ready), 32'h0);
      chk("t4_vld",  32'(bus.rsp_valid), 32'h4);
      chk("t4_data", 32'(bus.rsp_data),  32'h23);
      nxt();
    end
    bus.rsp_ready = '1;
    #1 chk("t4_resume", 32'(bus.req_ready), 32'h4);
    nxt();
    bus.req_valid = '0;
    repeat (5) nxt();

    // 5: reset with three operations in flight
    do_reset();
    for (int i = 0; i < NB_REQ; i++) set_op(i, 8'(i + 1), 8'd3, 1'b0);
    bus.rsp_ready = '1;
    bus.req_valid = '1;
    repeat (3) nxt();
    bus.req_valid = '0;
    #1 chk("t5_pre", 32'(bus.rsp_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_vld", 32'(bus.rsp_valid), 32'h0);
    chk("t5_async_en",  32'(mult_enable),   32'h1);
    chk("t5_async_id",  32'(bus.rsp_id),    32'h0);
    nxt(); rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("t5_quiet", 32'(bus.rsp_valid), 32'h0);
      nxt();
    end
    bus.req_valid = '1;
    #1 chk("t5_first", 32'(bus.req_ready), 32'h1);
    nxt();
    bus.req_valid = '0;
    repeat (4) nxt();

    // 6: requesters 1 and 3 alternate starting from last=1
    do_reset();
    bus.rsp_ready = '1;
    bus.req_valid = 4'b0010;
    #1 chk("t6_seed", 32'(bus.req_ready), 32'h2);
    nxt();
    bus.req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1 chk("t6_alt", 32'(bus.req_ready), (c % 2 == 0) ? 32'h8 : 32'h2);
      nxt();
    end
    bus.req_valid = '0;
    repeat (4) nxt();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/multiplier_arbiter.md
Name: multiplier_arbiter

Overview:
Shares one pipelined signed/unsigned multiplier between NB_REQ requesters. Each requester has a valid/ready operand channel and a valid/ready result channel. The block round-robin arbitrates the operand channels and drives the multiplier ports. It carries a valid/id tag alongside the multiplier pipeline and steers each product back to its originator. Result backpressure freezes the multiplier and the tag pipeline through the multiplier's enable.

Parameters:
NB_REQ, 4, number of requesters (>=2)
WIDTH_A, 32, operand A width
WIDTH_B, 32, operand B width
NB_EXTRA_REG, 4, multiplier extra output registers (>=1); multiplier latency LAT = NB_EXTRA_REG+1
ID_W, $clog2(NB_REQ), requester id width (localparam)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NB_REQ  operand valid per requester
req_ready  out  NB_REQ  operand accepted this cycle
req_signed  in  NB_REQ  per-requester signed flag
req_a  in  NB_REQ*WIDTH_A  flattened operand A, requester i at [i*WIDTH_A +: WIDTH_A]
req_b  in  NB_REQ*WIDTH_B  flattened operand B
rsp_valid  out  NB_REQ  result valid, at most one bit set
rsp_ready  in  NB_REQ  result accepted by requester
rsp_data  out  WIDTH_A+WIDTH_B  product, shared by all requesters
rsp_id  out  ID_W  id of the head result
mult_enable  out  1  to multiplier enable
mult_is_signed  out  1  to multiplier is_signed
mult_a  out  WIDTH_A  to multiplier a
mult_b  out  WIDTH_B  to multiplier b
mult_out  in  WIDTH_A+WIDTH_B  from multiplier out

Behaviour:
- Tag pipeline: LAT stages of {vld, id}. Stage 0 loads the grant; stage k loads stage k-1. It advances only when mult_enable=1, so it stays aligned with the multiplier.
- Head = stage LAT-1. stall = head.vld & ~rsp_ready[head.id]. mult_enable = ~stall.
- An invalid head never stalls, so bubbles are squeezed out even when all rsp_ready are 0.
- rsp_valid = head.vld ? onehot(head.id) : 0. rsp_data = mult_out. rsp_id = head.id.
- A result transfers when rsp_valid[i] & rsp_ready[i]. rsp_data is held stable while stalled, because the multiplier is frozen.
- Arbitration is round-robin with pointer last, the last granted id. Search starts at last+1 and wraps modulo NB_REQ.
- grant = first req_valid found by the search; gvld = |req_valid.
- req_ready = onehot(grant) when gvld & mult_enable, else 0.
- last updates to grant only when a transfer occurs.
- Requesters must not make req_valid depend on req_ready.
- Combinational mux to the multiplier: mult_a = req_a[grant], mult_b = req_b[grant], mult_is_signed = req_signed[grant]. When no request is pending, the mux drives the values selected by last; the tag vld is 0 in that case.
- Stage 0 vld = gvld & mult_enable on each advancing edge.
- Latency: an operand accepted at edge N gives rsp_valid at cycle N+LAT, absent stalls.
- Throughput: one operation per cycle.
- Reset (async assert, sync release): all tag vld=0, last=NB_REQ-1 (so requester 0 wins first). Outputs: rsp_valid=0, req_ready=0, mult_enable=1, rsp_id=0.
- Reset mid-operation: in-flight operations are discarded and never reported. Stale data left in the multiplier (which has no reset) is masked by vld=0.
- Simultaneous events: a result transfer at the head and a new grant on the same edge are both allowed.
- During a stall, no grant and no pointer update occur.
- Product width rules are those of the multiplier: the low WIDTH_A+WIDTH_B bits, with sign-extension selected by the requester's signed flag.

Decomposition:
- Shared package multiplier_pkg: LAT computation function and id-width clog2 function.
- Sub-module rr_arbiter (NB_REQ): req vector, advance strobe → onehot grant, grant id, gvld; pointer held internally with async reset.
- The multiplier is instantiated at top level next to this block, not inside it.
- The bench wraps arbiter plus multiplier.

Test Plan (NB_REQ=4, WIDTH_A=WIDTH_B=8, NB_EXTRA_REG=2, LAT=3):
1. Requester 0 only, a=0xFF, b=0x02, signed=1, accepted at cycle 0 → rsp_valid=4'b0001 at cycle 3, rsp_data=0xFFFE. Same operands with signed=0 → 0x01FE.
2. All four requesters valid continuously, rsp_ready=all 1 → grants 0,1,2,3,0,… one per cycle. rsp_id sequence matches the grant order with 3-cycle offset. Products correct for a=i+1, b=3 (3, 6, 9, 12).
3. Requester 1 holds rsp_ready=0 for 5 cycles while its result is at the head → mult_enable=0, req_ready=0, rsp_data stable for 5 cycles. Pipeline resumes with no loss or duplication.
4. rsp_ready=0 for all requesters, empty pipeline, requester 2 issuing back-to-back → 3 accepts, then a stall once the first result reaches the head.
5. rst_n asserted with 3 operations in flight → rsp_valid=0 immediately, before any clock edge. After release, no spurious results; first grant goes to requester 0.
6. Requesters 1 and 3 valid, last=1 → requester 3 is granted, then requester 1, alternating.
